// File: rtl/morse_key_decoder_if.sv
// Signal bundle between the Morse key front end and the letter decoder.
// The decoder takes the slave side; whoever supplies key and ticks takes the master side.
interface morse_key_decoder_if #(
    parameter int MAX_SYMBOLS = 5
);
    logic                   tick_100ms;
    logic                   key;
    logic                   window_timeout;
    logic [MAX_SYMBOLS-1:0] sym_bits;
    logic [2:0]             sym_len;
    logic                   letter_valid;
    logic                   overflow;
    logic                   timed_out;
    logic                   busy;

    modport master (
        output tick_100ms, key, window_timeout,
        input  sym_bits, sym_len, letter_valid, overflow, timed_out, busy
    );

    modport slave (
        input  tick_100ms, key, window_timeout,
        output sym_bits, sym_len, letter_valid, overflow, timed_out, busy
    );
endinterface

// File: rtl/morse_key_decoder.sv
// Turns a debounced Morse key into dot/dash letter codes timed by the 100 ms tick;
// an answer-window timeout forces out whatever letter is in progress.
module morse_key_decoder #(
    parameter int DASH_TICKS  = 3,
    parameter int GAP_TICKS   = 5,
    parameter int MAX_SYMBOLS = 5
) (
    input logic                clk,
    input logic                rst,
    morse_key_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [3:0] DASH_CNT = 4'(DASH_TICKS);
    localparam logic [3:0] GAP_CNT  = 4'(GAP_TICKS);
    localparam logic [2:0] MAX_LEN  = 3'(MAX_SYMBOLS);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t                 state;
    state_t                 state_n;
    logic [3:0]             press_cnt;
    logic [3:0]             press_cnt_n;
    logic [3:0]             gap_cnt;
    logic [3:0]             gap_cnt_n;
    logic [MAX_SYMBOLS-1:0] acc_bits;
    logic [MAX_SYMBOLS-1:0] acc_bits_n;
    logic [2:0]             acc_len;
    logic [2:0]             acc_len_n;
    logic                   acc_ovf;
    logic                   acc_ovf_n;

    logic [MAX_SYMBOLS-1:0] commit_bits;
    logic [2:0]             commit_len;
    logic                   commit_ovf;

    logic                   emit;
    logic                   emit_to;
    logic [MAX_SYMBOLS-1:0] emit_bits;
    logic [2:0]             emit_len;
    logic                   emit_ovf;

    logic [MAX_SYMBOLS-1:0] sym_bits;
    logic [2:0]             sym_len;
    logic                   letter_valid;
    logic                   overflow;
    logic                   timed_out;

    // Accumulator contents as they would be once the current press is committed.
    always_comb begin
        commit_bits = acc_bits;
        commit_len  = acc_len;
        commit_ovf  = acc_ovf;
        if (acc_len < MAX_LEN) begin
            for (int i = 0; i < MAX_SYMBOLS; i++) begin
                if (3'(i) == acc_len) begin
                    commit_bits[i] = (press_cnt >= DASH_CNT);
                end
            end
            commit_len = acc_len + 3'd1;
        end else begin
            commit_ovf = 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        press_cnt_n = press_cnt;
        gap_cnt_n   = gap_cnt;
        acc_bits_n  = acc_bits;
        acc_len_n   = acc_len;
        acc_ovf_n   = acc_ovf;
        emit        = 1'b0;
        emit_to     = 1'b0;
        emit_bits   = acc_bits;
        emit_len    = acc_len;
        emit_ovf    = acc_ovf;

        // The window timeout outranks key and tick activity everywhere except HOLD.
        if (state != HOLD && bus.window_timeout) begin
            emit       = 1'b1;
            emit_to    = 1'b1;
            state_n    = IDLE;
            acc_bits_n = '0;
            acc_len_n  = '0;
            acc_ovf_n  = 1'b0;
            if (state == IDLE) begin
                emit_bits = '0;
                emit_len  = '0;
                emit_ovf  = 1'b0;
            end else if (state == PRESS) begin
                emit_bits = commit_bits;
                emit_len  = commit_len;
                emit_ovf  = commit_ovf;
                if (bus.key) begin
                    state_n = HOLD;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.key) begin
                        state_n     = PRESS;
                        press_cnt_n = '0;
                        acc_bits_n  = '0;
                        acc_len_n   = '0;
                        acc_ovf_n   = 1'b0;
                    end
                end
                PRESS: begin
                    if (!bus.key) begin
                        state_n    = RELEASE;
                        gap_cnt_n  = '0;
                        acc_bits_n = commit_bits;
                        acc_len_n  = commit_len;
                        acc_ovf_n  = commit_ovf;
                    end else if (bus.tick_100ms) begin
                        press_cnt_n = sat_inc(press_cnt);
                    end
                end
                RELEASE: begin
                    if (bus.key) begin
                        state_n     = PRESS;
                        press_cnt_n = '0;
                    end else if (bus.tick_100ms) begin
                        gap_cnt_n = sat_inc(gap_cnt);
                        if (sat_inc(gap_cnt) >= GAP_CNT) begin
                            emit       = 1'b1;
                            state_n    = IDLE;
                            acc_bits_n = '0;
                            acc_len_n  = '0;
                            acc_ovf_n  = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.key) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            press_cnt <= '0;
            gap_cnt   <= '0;
            acc_bits  <= '0;
            acc_len   <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            press_cnt <= press_cnt_n;
            gap_cnt   <= gap_cnt_n;
            acc_bits  <= acc_bits_n;
            acc_len   <= acc_len_n;
            acc_ovf   <= acc_ovf_n;
        end
    end

    // Letter outputs hold their last value until the next emit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            letter_valid <= 1'b0;
            sym_bits     <= '0;
            sym_len      <= '0;
            overflow     <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            letter_valid <= emit;
            if (emit) begin
                sym_bits  <= emit_bits;
                sym_len   <= emit_len;
                overflow  <= emit_ovf;
                timed_out <= emit_to;
            end
        end
    end

    assign bus.sym_bits     = sym_bits;
    assign bus.sym_len      = sym_len;
    assign bus.letter_valid = letter_valid;
    assign bus.overflow     = overflow;
    assign bus.timed_out    = timed_out;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: a symbol-queue model checked every cycle, plus
// literal expectations for each directed letter.
module tb_morse_key_decoder;
    localparam int DASH = 3;
    localparam int GAP  = 5;
    localparam int MAXS = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    morse_key_decoder_if #(.MAX_SYMBOLS(MAXS)) bus ();

    morse_key_decoder #(
        .DASH_TICKS (DASH),
        .GAP_TICKS  (GAP),
        .MAX_SYMBOLS(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MAXS-1:0] bits;
        logic [2:0]      len;
        logic            ovf;
        logic            to;
    } letter_t;
    letter_t seen[$];

    // Model: presses are kept as a list of dash flags and truncated only at emit time.
    bit syms[$];
    bit m_press = 0;
    bit m_gap = 0;
    bit m_hold = 0;
    int press_ticks = 0;
    int gap_ticks = 0;
    logic            e_valid = 0;
    logic            e_busy = 0;
    logic [MAXS-1:0] e_bits = 0;
    logic [2:0]      e_len = 0;
    logic            e_ovf = 0;
    logic            e_to = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_emit(input bit to);
        int n;
        n = syms.size();
        e_valid = 1'b1;
        e_len   = 3'((n > MAXS) ? MAXS : n);
        e_ovf   = (n > MAXS);
        e_to    = to;
        e_bits  = '0;
        for (int i = 0; i < n && i < MAXS; i++) begin
            e_bits[i] = syms[i];
        end
        syms.delete();
    endtask

    task automatic model_step(input logic r, input logic k, input logic t, input logic w);
        e_valid = 1'b0;
        if (!r) begin
            syms.delete();
            m_press = 0; m_gap = 0; m_hold = 0;
            press_ticks = 0; gap_ticks = 0;
            e_bits = '0; e_len = '0; e_ovf = 0; e_to = 0;
        end else if (m_hold) begin
            if (!k) m_hold = 0;
        end else if (w) begin
            if (m_press) syms.push_back(press_ticks >= DASH);
            model_emit(1'b1);
            m_hold  = m_press && k;
            m_press = 0;
            m_gap   = 0;
        end else if (m_press) begin
            if (!k) begin
                syms.push_back(press_ticks >= DASH);
                m_press = 0; m_gap = 1; gap_ticks = 0;
            end else if (t) begin
                press_ticks = (press_ticks >= 15) ? 15 : press_ticks + 1;
            end
        end else if (m_gap) begin
            if (k) begin
                m_gap = 0; m_press = 1; press_ticks = 0;
            end else if (t) begin
                gap_ticks++;
                if (gap_ticks >= GAP) begin
                    model_emit(1'b0);
                    m_gap = 0;
                end
            end
        end else if (k) begin
            m_press = 1; press_ticks = 0;
            syms.delete();
        end
        e_busy = m_press || m_gap || m_hold;
    endtask

    // Compare the result of the last edge, then predict the next edge from the settled inputs.
    initial begin
        forever begin
            @(negedge clk);
            chk("letter_valid", bus.letter_valid, e_valid);
            chk("busy", bus.busy, e_busy);
            chk("sym_bits", bus.sym_bits, e_bits);
            chk("sym_len", bus.sym_len, e_len);
            chk("overflow", bus.overflow, e_ovf);
            chk("timed_out", bus.timed_out, e_to);
            if (bus.letter_valid === 1'b1) begin
                seen.push_back('{bits: bus.sym_bits, len: bus.sym_len,
                                 ovf: bus.overflow, to: bus.timed_out});
            end
            model_step(rst, bus.key, bus.tick_100ms, bus.window_timeout);
        end
    end

    task automatic cyc(input logic k, input logic t, input logic w);
        @(posedge clk);
        #1;
        bus.key            = k;
        bus.tick_100ms     = t;
        bus.window_timeout = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input int n);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic gap(input int n);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic expect_letter(input string name, input logic [MAXS-1:0] bits,
                                 input logic [2:0] len, input logic ovf, input logic to);
        letter_t l;
        if (seen.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no letter_valid seen, required bits=%b len=%0d", name, bits, len);
        end else begin
            l = seen.pop_front();
            chk({name, ".bits"}, l.bits, bits);
            chk({name, ".len"}, l.len, len);
            chk({name, ".ovf"}, l.ovf, ovf);
            chk({name, ".to"}, l.to, to);
        end
    endtask

    initial begin
        bus.key            = 1'b1;
        bus.tick_100ms     = 1'b0;
        bus.window_timeout = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.letter_valid", bus.letter_valid, 0);
        chk("reset.busy", bus.busy, 0);
        chk("reset.sym_bits", bus.sym_bits, 0);
        chk("reset.sym_len", bus.sym_len, 0);
        @(posedge clk);
        #1;
        bus.key = 1'b0;
        rst     = 1'b1;
        idle(3);
        chk("reset.no_strobe", seen.size(), 0);

        // Letter A: dot then dash
        press(1); gap(1); press(4); gap(5); idle(3);
        expect_letter("A", 5'b00010, 3'd2, 1'b0, 1'b0);
        chk("A.single", seen.size(), 0);

        // Dash threshold
        press(2); gap(5); idle(2);
        expect_letter("two_ticks", 5'b00000, 3'd1, 1'b0, 1'b0);
        press(3); gap(5); idle(2);
        expect_letter("three_ticks", 5'b00001, 3'd1, 1'b0, 1'b0);

        // Overflow: six dots
        for (int i = 0; i < 5; i++) begin
            press(1); gap(1);
        end
        press(1); gap(5); idle(3);
        expect_letter("overflow", 5'b00000, 3'd5, 1'b1, 1'b0);
        chk("overflow.single", seen.size(), 0);

        // Timeout while the key is held
        press(1); gap(1); press(4);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold.busy", bus.busy, 1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold.busy_late", bus.busy, 1);
        expect_letter("timeout_press", 5'b00010, 3'd2, 1'b0, 1'b1);
        chk("hold.no_second", seen.size(), 0);
        idle(2);
        @(negedge clk);
        chk("hold.released", bus.busy, 0);

        // Gap race: key returns on the gap-completing tick
        press(1); gap(4);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("race.no_strobe", seen.size(), 0);
        chk("race.busy", bus.busy, 1);
        gap(5); idle(2);
        expect_letter("race_letter", 5'b00000, 3'd2, 1'b0, 1'b0);

        // Timeout in IDLE
        cyc(1'b0, 1'b0, 1'b1);
        idle(2);
        expect_letter("timeout_idle", 5'b00000, 3'd0, 1'b0, 1'b1);

        // Reset mid-letter discards it
        press(2);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bus.key = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(8);
        @(negedge clk);
        chk("midreset.no_strobe", seen.size(), 0);
        chk("midreset.busy", bus.busy, 0);
        chk("midreset.sym_len", bus.sym_len, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Converts a debounced Morse key into one letter code (dot/dash sequence plus length) using the 100 ms tick stream as its time base. It consumes the five-second answer-window timeout pulse produced by the five-second timer so that an unfinished letter is forced out when the window closes. Its output feeds the game's letter-compare stage against the ROM target.

## Interface
- DASH_TICKS, 3: a press lasting ≥ DASH_TICKS ticks is a dash; fewer is a dot.
- GAP_TICKS, 5: a release lasting GAP_TICKS ticks ends the letter.
- MAX_SYMBOLS, 5: symbol capacity; sym_bits width = MAX_SYMBOLS.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- tick_100ms  in  1  one-cycle pulse every 100 ms.
- key  in  1  debounced key level, 1 = pressed.
- window_timeout  in  1  one-cycle pulse when the five-second answer window expires.
- sym_bits  out  MAX_SYMBOLS  letter code, bit i = symbol i (first symbol at bit 0), 1 = dash, unused bits 0.
- sym_len  out  3  number of valid symbols, 0..MAX_SYMBOLS.
- letter_valid  out  1  one-cycle strobe; sym_bits, sym_len, overflow, timed_out are valid.
- overflow  out  1  letter had more than MAX_SYMBOLS presses; extra symbols were dropped.
- timed_out  out  1  letter was terminated by window_timeout.
- busy  out  1  high in PRESS, RELEASE and HOLD.

## Operation
- Reset (rst=0 at posedge): state IDLE; all outputs 0; press_cnt, gap_cnt, and accumulators cleared. Reset mid-letter discards the letter with no strobe.
- Counters press_cnt and gap_cnt are 4-bit, increment only on tick_100ms, and saturate at 15.
- States:
  - IDLE: key=1 → PRESS, press_cnt=0, accumulator cleared.
  - PRESS: key=0 → commit symbol (dash iff press_cnt ≥ DASH_TICKS), → RELEASE, gap_cnt=0.
  - RELEASE: key=1 → PRESS, press_cnt=0. A tick making gap_cnt reach GAP_TICKS → emit letter, → IDLE.
  - HOLD: waits for key=0, then → IDLE. Ticks are ignored.
- Commit: if acc_len < MAX_SYMBOLS, write the bit at index acc_len and increment acc_len. Otherwise drop the symbol and set acc_ovf.
- Emit: on the same edge, load sym_bits, sym_len, overflow and timed_out from the accumulators and pulse letter_valid. The outputs hold until the next emit.
- window_timeout (checked before key/tick logic):
  - In IDLE: emit sym_len=0, sym_bits=0, timed_out=1 → IDLE.
  - In PRESS: commit the current press, then emit with timed_out=1. → HOLD if key=1, else → IDLE.
  - In RELEASE: emit with timed_out=1 → IDLE.
  - In HOLD: ignored.
- Simultaneous events:
  - In PRESS, a key release and a tick in the same cycle: the tick is not counted.
  - In RELEASE, key=1 and the gap-completing tick in the same cycle: key wins, no emit.

## Timing
- The state register and all outputs are registered.
- letter_valid rises on the clock edge that samples the terminating event (gap-completing tick or window_timeout), which is a 1-cycle latency. It is high for exactly one cycle.
- Symbol commit happens on the edge that samples key=0 in PRESS.
- Back-to-back letters: the next PRESS may begin the cycle after the emit.
- Minimum inter-letter spacing from the key is GAP_TICKS ticks.
- busy falls on the same edge as the letter_valid rise, except for a timeout emit entered from PRESS with key held, where busy stays high through HOLD.

## Test plan
- Reset: hold rst=0 for 3 cycles with key=1 → all outputs 0, busy=0, no strobe.
- Letter "A": press 1 tick, release 1 tick, press 4 ticks, release 5 ticks → one letter_valid, sym_bits=00010, sym_len=2, overflow=0, timed_out=0.
- Dash threshold: press exactly 2 ticks vs exactly 3 ticks (separate letters) → sym_bits bit0 = 0 then 1, sym_len=1 each.
- Overflow: six 1-tick presses, then a 5-tick gap → sym_len=5, sym_bits=00000, overflow=1, a single strobe.
- Timeout in PRESS: one dot committed, second press held 4 ticks, window_timeout pulsed while key=1 → sym_bits=00010, sym_len=2, timed_out=1. busy stays 1 until key=0 and there is no second strobe.
- Gap race: in RELEASE with gap_cnt=4, key=1 on the same cycle as the tick → no letter_valid, state PRESS. Timeout in IDLE → letter_valid with sym_len=0, timed_out=1.
